// File: rtl/axilite_pkg.sv
// Shared AXI-Lite definitions: error flag bit positions, AxPROT bit
// positions and the response encodings used by the register-access logic.
package axilite_pkg;

  localparam int ERR_W        = 2;
  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE    = 1;

  localparam int PROT_W       = 3;
  localparam int PROT_PRIV    = 0;
  localparam int PROT_NONSEC  = 1;
  localparam int PROT_INSTR   = 2;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

endpackage

// File: rtl/axilite_addr_classify.sv
// Combinational address classifier: flags misaligned addresses and
// addresses outside [BASE_ADDR, BASE_ADDR + SPAN). The upper bound is
// formed one bit wider than the address so a window ending at the top of
// the address space does not wrap to zero.
module axilite_addr_classify
  import axilite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_BYTES = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_WIDTH-1:0] SPAN       = 'h1000
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [ERR_W-1:0]      err
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(DATA_BYTES - 1);
  localparam logic [ADDR_WIDTH:0]   WIN_LO     = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0]   WIN_HI     = WIN_LO + {1'b0, SPAN};

  logic [ADDR_WIDTH:0] addr_ext;

  // Alignment test on the low address bits, window test at extended width
  always_comb begin
    err               = '0;
    addr_ext          = {1'b0, addr};
    err[ERR_MISALIGN] = |(addr & ALIGN_MASK);
    err[ERR_RANGE]    = (addr_ext < WIN_LO) || (addr_ext >= WIN_HI);
  end

endmodule

// File: rtl/axilite_addr_queue.sv
// AXI-Lite address-channel receiver: accepts AR/AW addresses into a
// first-word-fall-through queue, classifying each one as it is captured.
// The head entry is held on registered outputs until the consumer pops it.
module axilite_addr_queue
  import axilite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter int                    DATA_BYTES = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_WIDTH-1:0] SPAN       = 'h1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [PROT_W-1:0]       prot,
  input  logic                    valid,
  output logic                    ready,
  output logic [ADDR_WIDTH-1:0]   held_addr,
  output logic [PROT_W-1:0]       held_prot,
  output logic [ERR_W-1:0]        addr_err,
  output logic                    addr_ready,
  input  logic                    deassert_addr,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [PROT_W-1:0]     mem_prot [DEPTH];
  logic [ERR_W-1:0]      mem_err  [DEPTH];

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_next;
  logic [LW-1:0]    level_next;
  logic [ERR_W-1:0] in_err;
  logic             push;
  logic             pop;
  logic             load_head;
  logic             head_from_input;

  axilite_addr_classify #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_BYTES (DATA_BYTES),
    .BASE_ADDR  (BASE_ADDR),
    .SPAN       (SPAN)
  ) u_classify (
    .addr (addr),
    .err  (in_err)
  );

  // Handshake decode, next occupancy, and where the next head comes from
  always_comb begin
    push            = valid && ready;
    pop             = deassert_addr && addr_ready;
    rd_ptr_next     = pop ? rd_ptr + PW'(1) : rd_ptr;
    level_next      = level;
    if (push && !pop) level_next = level + LW'(1);
    if (pop && !push) level_next = level - LW'(1);
    load_head       = (level_next != '0) && (pop || (level == '0));
    head_from_input = (rd_ptr_next == wr_ptr);
  end

  // Queue storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= addr;
      mem_prot[wr_ptr] <= prot;
      mem_err[wr_ptr]  <= in_err;
    end
  end

  // Pointers, occupancy, registered handshake flags and head outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      ready      <= 1'b0;
      addr_ready <= 1'b0;
      held_addr  <= '0;
      held_prot  <= '0;
      addr_err   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr     <= rd_ptr_next;
      level      <= level_next;
      ready      <= (level_next < LW'(DEPTH));
      addr_ready <= (level_next != '0);
      if (load_head) begin
        if (head_from_input) begin
          held_addr <= addr;
          held_prot <= prot;
          addr_err  <= in_err;
        end else begin
          held_addr <= mem_addr[rd_ptr_next];
          held_prot <= mem_prot[rd_ptr_next];
          addr_err  <= mem_err[rd_ptr_next];
        end
      end
    end
  end

endmodule
